// File: rtl/mem_march_ctrl.sv
// March-style BIST sequencer for one 256x16 RAM: write P, verify P, write ~P, verify ~P.
// Optional MEM_MARCH_LOOP_EN: repeat passes while start stays high, exposing loop_count.
module mem_march_ctrl #(
  parameter int          ADDR_W    = 8,
  parameter int          ERR_CNT_W = 16,
  parameter logic [15:0] SEED      = 16'hA5C3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 first_err_valid,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [1:0]           phase,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_cs,
  output logic                 mem_rw,
  output logic                 mem_byte_sel,
  output logic [15:0]          mem_wdata,
  input  logic [7:0]           mem_rdata_byte
`ifdef MEM_MARCH_LOOP_EN
  ,
  output logic [15:0]          loop_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD_ISSUE, S_RD_LO, S_RD_HI, S_DONE
  } state_t;

  state_t                state, state_n;
  logic                  busy_n, done_n, pass_n, fev_n;
  logic                  cs_n, rw_n, bs_n;
  logic [ERR_CNT_W-1:0]  err_n;
  logic [ADDR_W-1:0]     fea_n, addr_n;
  logic [1:0]            phase_n;
  logic [15:0]           wdata_n, rd_word;
  logic [7:0]            lo, lo_n;
  logic                  last_addr;
`ifdef MEM_MARCH_LOOP_EN
  logic [15:0]           loop_n;
`endif

  // Expected word: P(a) = {a, ~a} ^ SEED, inverted in the ~P phases (phase[1] set).
  function automatic logic [15:0] exp_word(input logic [ADDR_W-1:0] a, input logic [1:0] ph);
    logic [15:0] p;
    p = 16'({a, ~a}) ^ SEED;
    return ph[1] ? ~p : p;
  endfunction

  assign last_addr = (mem_addr == {ADDR_W{1'b1}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= S_IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      phase           <= 2'd0;
      mem_addr        <= '0;
      mem_cs          <= 1'b0;
      mem_rw          <= 1'b0;
      mem_byte_sel    <= 1'b0;
      mem_wdata       <= '0;
      lo              <= '0;
`ifdef MEM_MARCH_LOOP_EN
      loop_count      <= '0;
`endif
    end else begin
      state           <= state_n;
      busy            <= busy_n;
      done            <= done_n;
      pass            <= pass_n;
      err_count       <= err_n;
      first_err_valid <= fev_n;
      first_err_addr  <= fea_n;
      phase           <= phase_n;
      mem_addr        <= addr_n;
      mem_cs          <= cs_n;
      mem_rw          <= rw_n;
      mem_byte_sel    <= bs_n;
      mem_wdata       <= wdata_n;
      lo              <= lo_n;
`ifdef MEM_MARCH_LOOP_EN
      loop_count      <= loop_n;
`endif
    end
  end

  // Next-state logic also computes the next registered outputs, so every
  // memory pin reflects the operation of the state being entered.
  always_comb begin
    state_n = state;
    busy_n  = busy;
    done_n  = 1'b0;
    pass_n  = pass;
    err_n   = err_count;
    fev_n   = first_err_valid;
    fea_n   = first_err_addr;
    phase_n = phase;
    addr_n  = mem_addr;
    cs_n    = mem_cs;
    rw_n    = mem_rw;
    bs_n    = mem_byte_sel;
    wdata_n = mem_wdata;
    lo_n    = lo;
    rd_word = {mem_rdata_byte, lo};
`ifdef MEM_MARCH_LOOP_EN
    loop_n  = loop_count;
`endif

    case (state)
      S_IDLE: begin
        cs_n = 1'b0;
        rw_n = 1'b0;
        bs_n = 1'b0;
        if (start) begin
          state_n = S_WR;
          busy_n  = 1'b1;
          pass_n  = 1'b0;
          err_n   = '0;
          fev_n   = 1'b0;
          phase_n = 2'd0;
          addr_n  = '0;
          cs_n    = 1'b1;
          rw_n    = 1'b1;
          wdata_n = exp_word('0, 2'd0);
`ifdef MEM_MARCH_LOOP_EN
          loop_n  = '0;
`endif
        end
      end

      S_WR: begin
        if (last_addr) begin
          state_n = S_RD_ISSUE;
          phase_n = phase + 2'd1;
          addr_n  = '0;
          rw_n    = 1'b0;
          bs_n    = 1'b0;
        end else begin
          addr_n  = mem_addr + 1'b1;
          wdata_n = exp_word(mem_addr + 1'b1, phase);
        end
      end

      S_RD_ISSUE: begin
        state_n = S_RD_LO;
        bs_n    = 1'b0;
      end

      S_RD_LO: begin
        lo_n    = mem_rdata_byte;
        state_n = S_RD_HI;
        bs_n    = 1'b1;
      end

      S_RD_HI: begin
        bs_n = 1'b0;
        if (rd_word != exp_word(mem_addr, phase)) begin
          if (err_count != {ERR_CNT_W{1'b1}}) err_n = err_count + 1'b1;
          if (!first_err_valid) begin
            fev_n = 1'b1;
            fea_n = mem_addr;
          end
        end
        if (!last_addr) begin
          state_n = S_RD_ISSUE;
          addr_n  = mem_addr + 1'b1;
        end else if (phase == 2'd3) begin
          state_n = S_DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          pass_n  = (err_n == '0);
          cs_n    = 1'b0;
          rw_n    = 1'b0;
`ifdef MEM_MARCH_LOOP_EN
          loop_n  = loop_count + 16'd1;
`endif
        end else begin
          state_n = S_WR;
          phase_n = 2'd2;
          addr_n  = '0;
          rw_n    = 1'b1;
          wdata_n = exp_word('0, 2'd2);
        end
      end

      S_DONE: begin
        cs_n    = 1'b0;
        rw_n    = 1'b0;
        bs_n    = 1'b0;
        state_n = S_IDLE;
`ifdef MEM_MARCH_LOOP_EN
        // Back-to-back pass: results stay cumulative across the loop.
        if (start) begin
          state_n = S_WR;
          busy_n  = 1'b1;
          phase_n = 2'd0;
          addr_n  = '0;
          cs_n    = 1'b1;
          rw_n    = 1'b1;
          wdata_n = exp_word('0, 2'd0);
        end
`endif
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
